instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Host-side issuer for the 16-bit external instruction port of the CPU core. A host loads a program of instructions into an internal FIFO, then pulses start. The block streams each instruction to the CPU as a one-cycle instruction_valid pulse with configurable spacing. After the last instruction it waits a fixed drain time, samples the CPU's 32-bit result and reports done.

Parameters:
DEPTH, 16, program FIFO entries (power of 2, >=2)
ISSUE_GAP, 0, idle cycles inserted after each issued instruction
DRAIN_CYCLES, 2, cycles waited after last issue before sampling result (>=1)
RESULT_W, 32, width of CPU result bus

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
wr_instr  in  16  instruction to enqueue
wr_valid  in  1  enqueue request
wr_ready  out  1  FIFO not full; enqueue occurs when wr_valid && wr_ready
start  in  1  one-cycle pulse, begin issuing FIFO contents
instruction_out  out  16  to CPU instruction_in
instruction_valid  out  1  to CPU instruction_valid, one-cycle pulse per instruction
result_in  in  RESULT_W  from CPU result
result_out  out  RESULT_W  captured result
busy  out  1  high in any state other than IDLE/DONE
done  out  1  high in DONE, cleared by next start or reset
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
err  out  1  sticky illegal-opcode flag (feature-dependent, else tied 0)

Behaviour:
- Reset (rst==0 at clk edge): FIFO emptied, state IDLE, all outputs 0 except wr_ready=1. Reset mid-program abandons the sequence with no further instruction_valid.
- Instruction format: [15:14] zero, [13:8] opcode, [7:0] immediate. Opcodes: 0 NOP, 1 LOADA, 2 LOADB, 3 ADD. The block forwards words unmodified.
- FIFO: writes are accepted in every state while not full. Simultaneous push and pop are allowed and leave count unchanged. Push is ignored when full. Read pointer wraps modulo DEPTH.
- FSM states: IDLE, ISSUE, GAP, DRAIN, CAPTURE, DONE.
- IDLE/DONE: start moves to ISSUE and clears done. Start is ignored in all other states.
- ISSUE:
  - If count>0: pop, register the word onto instruction_out, and assert instruction_valid for exactly the next cycle. Go to GAP if ISSUE_GAP>0, else stay in ISSUE.
  - If count==0: go to DRAIN. Emptiness is judged on registered count, so a push in the same cycle is not seen until the next ISSUE visit.
- GAP: counts ISSUE_GAP cycles with instruction_valid=0, then returns to ISSUE.
- Issue rate: with ISSUE_GAP=0, back-to-back instructions issue every cycle.
- Latency: start sampled at edge k gives the first instruction_valid high in the cycle after edge k+1.
- instruction_out holds its last value when instruction_valid is low.
- DRAIN: counts DRAIN_CYCLES, then goes to CAPTURE. DRAIN_CYCLES counts from the cycle after the last instruction_valid.
- CAPTURE: result_out <= result_in, then go to DONE. result_out holds until the next CAPTURE or reset.
- Start with an empty FIFO: ISSUE → DRAIN → CAPTURE → DONE with no instruction_valid pulses.

Optional Feature:
Macro INSTR_SEQ_OPCODE_CHECK_EN.
- Defined: in ISSUE, a popped word with opcode>3 or nonzero [15:14] is discarded. No instruction_valid is raised for it, err is set sticky (cleared only by reset), and sequencing continues with the next entry in the following cycle.
- Undefined: all words are forwarded unchanged and err is tied 0.

Decomposition:
- Package instr_seq_pkg holds:
  - opcode localparams (OP_NOP=6'd0, OP_LOADA=6'd1, OP_LOADB=6'd2, OP_ADD=6'd3);
  - instruction field slice constants;
  - the state enum typedef.
- One sub-module, seq_fifo: parameterised synchronous FIFO with count, full, empty, and push/pop.
- The FSM, gap/drain counters and capture register live in instr_sequencer.

Test Plan:
- Program LOADA 45 (16'h012D), LOADB 54 (16'h0236), ADD (16'h0300), NOP; start, CPU connected → four valid pulses on consecutive cycles in that order; done rises; result_out=99.
- ISSUE_GAP=2, same program → valid pulses exactly 3 cycles apart; instruction_out stable between pulses.
- Fill FIFO with 16 words → wr_ready=0; 17th push ignored; fifo_count=16; all 16 issued in order and the pointer wraps correctly on a refill.
- Start with empty FIFO → no instruction_valid; done asserted after DRAIN_CYCLES+2 cycles; result_out equals current result_in.
- Assert rst low after second instruction issued → no further valid; fifo_count=0, done=0, busy=0, result_out=0 next cycle.
- With INSTR_SEQ_OPCODE_CHECK_EN, program LOADA 7, 16'h3F00, ADD → only two valid pulses; err=1, held until reset.

Source files
------------

// File: rtl/instr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_seq_pkg
// Desc     : Shared opcodes, instruction field slices and FSM encoding for
//            the instruction sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package instr_seq_pkg;

    localparam int INSTR_W = 16;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LOADA = 6'd1;
    localparam logic [5:0] OP_LOADB = 6'd2;
    localparam logic [5:0] OP_ADD   = 6'd3;

    localparam int RSV_MSB = 15;
    localparam int RSV_LSB = 14;
    localparam int OP_MSB  = 13;
    localparam int OP_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_ISSUE   = 3'd1;
    localparam state_t S_GAP     = 3'd2;
    localparam state_t S_DRAIN   = 3'd3;
    localparam state_t S_CAPTURE = 3'd4;
    localparam state_t S_DONE    = 3'd5;

    // Legal words have zero reserved bits and one of the four defined opcodes.
    function automatic logic opcode_legal(input logic [INSTR_W-1:0] word);
        return (word[RSV_MSB:RSV_LSB] == 2'b00) && (word[OP_MSB:OP_LSB] <= OP_ADD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : seq_fifo
// Desc     : Synchronous power-of-two FIFO with occupancy count; push is
//            dropped when full, pop is ignored when empty.
// Revision : 1.0 - initial release
// ============================================================================
module seq_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full    = (r_count == c_depth);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Desc     : Streams a host-loaded program to the CPU instruction port, then
//            drains and captures the CPU result. Optional opcode filtering is
//            enabled with INSTR_SEQ_OPCODE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ISSUE_GAP    = 0,
    parameter int DRAIN_CYCLES = 2,
    parameter int RESULT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             wr_instr,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic                    start,
    output logic [15:0]             instruction_out,
    output logic                    instruction_valid,
    input  logic [RESULT_W-1:0]     result_in,
    output logic [RESULT_W-1:0]     result_out,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    err
);

    localparam logic [15:0] c_gap_last   = 16'(ISSUE_GAP - 1);
    localparam logic [15:0] c_drain_last = 16'(DRAIN_CYCLES - 1);

    state_t                r_state;
    logic [15:0]           r_cnt;
    logic [15:0]           r_instr;
    logic                  r_valid;
    logic [RESULT_W-1:0]   r_result;

    logic [15:0]           w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_discard;

    assign w_pop = (r_state == S_ISSUE) && !w_empty;

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_valid),
        .wr_data (wr_instr),
        .pop     (w_pop),
        .rd_data (w_head),
        .count   (fifo_count),
        .full    (w_full),
        .empty   (w_empty)
    );

`ifdef INSTR_SEQ_OPCODE_CHECK_EN
    logic r_err;

    assign w_discard = !opcode_legal(w_head);
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_pop && w_discard) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_discard = 1'b0;
    assign err       = 1'b0;
`endif

    assign wr_ready          = !w_full;
    assign instruction_out   = r_instr;
    assign instruction_valid = r_valid;
    assign result_out        = r_result;
    assign busy              = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done              = (r_state == S_DONE);

    // r_cnt is shared by GAP and DRAIN; the two states never overlap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_empty) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= '0;
                    end else if (!w_discard) begin
                        r_instr <= w_head;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        if (ISSUE_GAP > 0) begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        r_state <= S_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == c_drain_last) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_CAPTURE: begin
                    r_result <= result_in;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Desc     : Directed self-checking bench for instr_sequencer with a small
//            accumulator CPU model and a second instance using ISSUE_GAP=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int DRAIN = 2;
    localparam int GAP   = 2;
    localparam logic [31:0] RESULT_G = 32'hA5A5_0042;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] wr_instr;
    logic        wr_valid, wr_ready, start;
    logic [15:0] instruction_out;
    logic        instruction_valid;
    logic [31:0] result_in, result_out;
    logic        busy, done, err;
    logic [4:0]  fifo_count;

    logic [15:0] wr_instr_g;
    logic        wr_valid_g, wr_ready_g, start_g;
    logic [15:0] instruction_out_g;
    logic        instruction_valid_g;
    logic [31:0] result_out_g;
    logic        busy_g, done_g, err_g;
    logic [4:0]  fifo_count_g;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    instr_sequencer #(.DEPTH(DEPTH), .ISSUE_GAP(0), .DRAIN_CYCLES(DRAIN), .RESULT_W(32)) dut (
        .clk(clk), .rst(rst), .wr_instr(wr_instr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .start(start), .instruction_out(instruction_out), .instruction_valid(instruction_valid),
        .result_in(result_in), .result_out(result_out), .busy(busy), .done(done),
        .fifo_count(fifo_count), .err(err)
    );

    instr_sequencer #(.DEPTH(DEPTH), .ISSUE_GAP(GAP), .DRAIN_CYCLES(DRAIN), .RESULT_W(32)) dut_g (
        .clk(clk), .rst(rst), .wr_instr(wr_instr_g), .wr_valid(wr_valid_g), .wr_ready(wr_ready_g),
        .start(start_g), .instruction_out(instruction_out_g), .instruction_valid(instruction_valid_g),
        .result_in(RESULT_G), .result_out(result_out_g), .busy(busy_g), .done(done_g),
        .fifo_count(fifo_count_g), .err(err_g)
    );

    // Accumulator CPU: LOADA/LOADB latch the immediate, ADD sums them.
    logic [7:0]  cpu_a, cpu_b;
    logic [31:0] cpu_acc;
    logic [31:0] result_bias = 32'h0;
    always @(posedge clk) begin
        if (!rst) begin
            cpu_a <= 8'd0; cpu_b <= 8'd0; cpu_acc <= 32'd0;
        end else if (instruction_valid) begin
            case (instruction_out[13:8])
                6'd1: cpu_a <= instruction_out[7:0];
                6'd2: cpu_b <= instruction_out[7:0];
                6'd3: cpu_acc <= 32'(cpu_a) + 32'(cpu_b);
                default: ;
            endcase
        end
    end
    assign result_in = cpu_acc ^ result_bias;

    task automatic push0(input logic [15:0] w);
        @(negedge clk); wr_instr = w; wr_valid = 1'b1;
        @(negedge clk); wr_valid = 1'b0;
    endtask

    task automatic push_g(input logic [15:0] w);
        @(negedge clk); wr_instr_g = w; wr_valid_g = 1'b1;
        @(negedge clk); wr_valid_g = 1'b0;
    endtask

    task automatic start0(output int k);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; k = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        n_checks++; if ({instruction_valid, busy, done, err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {instruction_valid, busy, done, err}); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if ({instruction_out, result_out} !== 48'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {instruction_out, result_out}); end
        n_checks++; if ({wr_ready_g, busy_g, done_g, err_g, fifo_count_g} !== {4'b1000, 5'd0}) begin n_fail++; $display("FAIL reset_gap_inst: got %b want 100000000", {wr_ready_g, busy_g, done_g, err_g, fifo_count_g}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_program();
        logic [15:0] words [4];
        int pc[$]; logic [15:0] pw[$];
        int k, done_cyc;
        words = '{16'h012D, 16'h0236, 16'h0300, 16'h0000};
        for (int i = 0; i < 4; i++) push0(words[i]);
        n_checks++; if (fifo_count !== 5'd4) begin n_fail++; $display("FAIL prog_count: got %0d want 4", fifo_count); end
        start0(k);
        done_cyc = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (instruction_valid) begin pc.push_back(cyc); pw.push_back(instruction_out); end
            if (done) begin done_cyc = cyc; break; end
        end
        n_checks++; if (pc.size() !== 4) begin n_fail++; $display("FAIL prog_npulses: got %0d want 4", pc.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= pc.size()) begin n_fail++; $display("FAIL prog_pulse%0d: got none want %h", i, words[i]); end
            else if (pw[i] !== words[i] || pc[i] !== k + 1 + i) begin
                n_fail++; $display("FAIL prog_pulse%0d: got %h at %0d want %h at %0d", i, pw[i], pc[i], words[i], k + 1 + i);
            end
        end
        n_checks++; if (done_cyc !== k + 4 + DRAIN + 2) begin n_fail++; $display("FAIL prog_done_time: got %0d want %0d", done_cyc, k + 4 + DRAIN + 2); end
        n_checks++; if (result_out !== 32'd99) begin n_fail++; $display("FAIL prog_result: got %0d want 99", result_out); end
        n_checks++; if ({busy, instruction_out} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL prog_idle: got %h want 0", {busy, instruction_out}); end
    endtask

    task automatic test_gap();
        logic [15:0] words [4];
        int pc[$]; logic [15:0] pw[$];
        int k; logic stable, seen_done;
        words = '{16'h012D, 16'h0236, 16'h0300, 16'h0000};
        for (int i = 0; i < 4; i++) push_g(words[i]);
        @(negedge clk); start_g = 1'b1;
        @(negedge clk); start_g = 1'b0; k = cyc;
        stable = 1'b1; seen_done = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (instruction_valid_g) begin pc.push_back(cyc); pw.push_back(instruction_out_g); end
            else if (pw.size() > 0 && instruction_out_g !== pw[pw.size()-1]) stable = 1'b0;
            if (done_g) begin seen_done = 1'b1; break; end
        end
        n_checks++; if (pc.size() !== 4) begin n_fail++; $display("FAIL gap_npulses: got %0d want 4", pc.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= pc.size()) begin n_fail++; $display("FAIL gap_pulse%0d: got none want %h", i, words[i]); end
            else if (pw[i] !== words[i] || pc[i] !== k + 1 + 3 * i) begin
                n_fail++; $display("FAIL gap_pulse%0d: got %h at %0d want %h at %0d", i, pw[i], pc[i], words[i], k + 1 + 3 * i);
            end
        end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL gap_hold: got unstable want stable"); end
        n_checks++; if (seen_done !== 1'b1 || result_out_g !== RESULT_G) begin n_fail++; $display("FAIL gap_result: got done=%b %h want 1 %h", seen_done, result_out_g, RESULT_G); end
    endtask

    task automatic test_full_wrap();
        logic [15:0] words [16];
        logic [15:0] refill [3];
        int pc[$]; logic [15:0] pw[$];
        int k; logic in_order;
        for (int i = 0; i < 16; i++) words[i] = 16'((i % 4) << 8) | 16'(16 + i);
        refill = '{16'h0102, 16'h0203, 16'h0300};
        for (int i = 0; i < 16; i++) push0(words[i]);
        n_checks++; if ({wr_ready, fifo_count} !== {1'b0, 5'd16}) begin n_fail++; $display("FAIL full_flags: got ready=%b cnt=%0d want 0 16", wr_ready, fifo_count); end
        push0(16'h0011);
        n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL full_overflow: got %0d want 16", fifo_count); end
        start0(k);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (instruction_valid) begin pc.push_back(cyc); pw.push_back(instruction_out); end
            if (done) break;
        end
        in_order = (pw.size() == 16);
        for (int i = 0; i < 16 && i < pw.size(); i++) if (pw[i] !== words[i]) in_order = 1'b0;
        n_checks++; if (in_order !== 1'b1) begin n_fail++; $display("FAIL full_order: got %0d pulses/out of order want 16 in order", pw.size()); end
        for (int i = 0; i < 3; i++) push0(refill[i]);
        pw.delete();
        start0(k);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (instruction_valid) pw.push_back(instruction_out);
            if (done) break;
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= pw.size() || pw[i] !== refill[i]) begin
                n_fail++; $display("FAIL wrap_pulse%0d: got %h want %h", i, (i < pw.size()) ? pw[i] : 16'hxxxx, refill[i]);
            end
        end
        n_checks++; if (result_out !== 32'd5) begin n_fail++; $display("FAIL wrap_result: got %0d want 5", result_out); end
    endtask

    task automatic test_empty_start();
        int k, done_cyc, nvalid;
        result_bias = 32'hDEAD_0000;
        start0(k);
        done_cyc = -1; nvalid = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (instruction_valid) nvalid++;
            if (done) begin done_cyc = cyc; break; end
        end
        n_checks++; if (nvalid !== 0) begin n_fail++; $display("FAIL empty_pulses: got %0d want 0", nvalid); end
        n_checks++; if (done_cyc !== k + DRAIN + 2) begin n_fail++; $display("FAIL empty_done_time: got %0d want %0d", done_cyc, k + DRAIN + 2); end
        n_checks++; if (result_out !== 32'hDEAD_0005) begin n_fail++; $display("FAIL empty_result: got %h want dead0005", result_out); end
        result_bias = 32'h0;
    endtask

    task automatic test_reset_mid();
        int k, npulse, nafter;
        logic [15:0] words [4];
        words = '{16'h012D, 16'h0236, 16'h0300, 16'h0000};
        for (int i = 0; i < 4; i++) push0(words[i]);
        start0(k);
        npulse = 0;
        for (int c = 0; c < 20 && npulse < 2; c++) begin
            @(negedge clk);
            if (instruction_valid) npulse++;
        end
        n_checks++; if (npulse !== 2) begin n_fail++; $display("FAIL rmid_reach: got %0d pulses want 2", npulse); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({fifo_count, done, busy, instruction_valid} !== 8'h00) begin n_fail++; $display("FAIL rmid_state: got cnt=%0d done=%b busy=%b vld=%b want 0", fifo_count, done, busy, instruction_valid); end
        n_checks++; if (result_out !== 32'd0) begin n_fail++; $display("FAIL rmid_result: got %h want 0", result_out); end
        rst = 1'b1;
        nafter = 0;
        repeat (10) begin @(negedge clk); if (instruction_valid) nafter++; end
        n_checks++; if (nafter !== 0) begin n_fail++; $display("FAIL rmid_no_issue: got %0d want 0", nafter); end
    endtask

    task automatic test_opcode_check();
        logic [15:0] words [3];
        logic [15:0] exp_w [$];
        logic [15:0] pw[$];
        logic exp_err;
        int k;
        words = '{16'h0107, 16'h3F00, 16'h0300};
`ifdef INSTR_SEQ_OPCODE_CHECK_EN
        exp_w = '{16'h0107, 16'h0300}; exp_err = 1'b1;
`else
        exp_w = '{16'h0107, 16'h3F00, 16'h0300}; exp_err = 1'b0;
`endif
        for (int i = 0; i < 3; i++) push0(words[i]);
        start0(k);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (instruction_valid) pw.push_back(instruction_out);
            if (done) break;
        end
        n_checks++; if (pw.size() !== exp_w.size()) begin n_fail++; $display("FAIL opc_npulses: got %0d want %0d", pw.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            n_checks++;
            if (i >= pw.size() || pw[i] !== exp_w[i]) begin
                n_fail++; $display("FAIL opc_pulse%0d: got %h want %h", i, (i < pw.size()) ? pw[i] : 16'hxxxx, exp_w[i]);
            end
        end
        repeat (5) @(negedge clk);
        n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL opc_err_sticky: got %b want %b", err, exp_err); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL opc_err_reset: got %b want 0", err); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_instr = 16'h0;
        start_g = 1'b0; wr_valid_g = 1'b0; wr_instr_g = 16'h0;
        test_reset();
        test_program();
        test_gap();
        test_full_wrap();
        test_empty_start();
        test_reset_mid();
        test_opcode_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
